// File: rtl/amba3_apb_mem_slave.sv
// APB3 slave fronting a word-addressed RAM, with optional wait states and PSLVERR on bad addresses.
// Latency: setup cycle + access cycle; the access phase is stretched by 0, WAIT_CYCLES or 0..WAIT_CYCLES waits.
// Backpressure: pready is held low while the wait counter is non-zero; the master holds penable until pready.
//
// Ports:
//   pclk, preset             rising-edge clock, synchronous active-high reset
//   psel, penable, pwrite    APB control from the master
//   paddr, pwdata            byte address and write data (sampled in the setup cycle only)
//   prdata, pready, pslverr  APB response; prdata is zero outside a good read completion
//   xfer_count, err_count    wrapping counts of good and error completions
module amba3_apb_mem_slave #(
    parameter int                   ADDR_SIZE   = 32,
    parameter int                   DATA_SIZE   = 32,
    parameter int                   MEM_DEPTH   = 1024,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR   = '0,
    parameter int                   WAIT_MODE   = 0,
    parameter int                   WAIT_CYCLES = 2,
    parameter logic [15:0]          LFSR_SEED   = 16'hACE1
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [ADDR_SIZE-1:0] paddr,
    input  logic [DATA_SIZE-1:0] pwdata,
    output logic [DATA_SIZE-1:0] prdata,
    output logic                 pready,
    output logic                 pslverr,
    output logic [15:0]          xfer_count,
    output logic [15:0]          err_count
);

    localparam int                   BYTE_BITS = $clog2(DATA_SIZE / 8);
    localparam int                   IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    // Byte-lane bits of paddr; a non-zero value here means a misaligned access.
    localparam logic [ADDR_SIZE-1:0] LANE_MASK = ADDR_SIZE'((64'd1 << BYTE_BITS) - 64'd1);
    localparam logic [ADDR_SIZE-1:0] DEPTH_A   = ADDR_SIZE'(MEM_DEPTH);
    // Galois feedback for x^16 + x^14 + x^13 + x^11 in right-shift form.
    localparam logic [15:0]          LFSR_TAPS = 16'hB400;
    localparam logic [4:0]           WAIT_MOD  = 5'(WAIT_CYCLES) + 5'd1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t               state_q;
    logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

    // Transfer context captured in the setup cycle; the bus may change afterwards.
    logic [IDX_W-1:0]     idx_q;
    logic                 wr_q;
    logic                 err_q;
    logic [DATA_SIZE-1:0] wdata_q;
    logic [3:0]           cnt_q;
    logic [15:0]          lfsr_q;

    logic [ADDR_SIZE-1:0] offset;
    logic [ADDR_SIZE-1:0] word_idx;
    logic                 addr_err;
    logic                 setup;
    logic                 complete;
    logic [3:0]           wait_load;
    logic [15:0]          lfsr_next;

    // Address decode against the memory window.
    always_comb begin
        offset   = paddr - BASE_ADDR;
        word_idx = offset >> BYTE_BITS;
        addr_err = (paddr < BASE_ADDR) ||
                   (word_idx >= DEPTH_A) ||
                   ((paddr & LANE_MASK) != '0);
    end

    // Wait-state count loaded at setup; random mode uses the LFSR value before it advances.
    always_comb begin
        lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        case (WAIT_MODE)
            1:       wait_load = 4'(WAIT_CYCLES);
            2:       wait_load = 4'({1'b0, lfsr_q[3:0]} % WAIT_MOD);
            default: wait_load = 4'd0;
        endcase
    end

    assign setup    = (state_q == IDLE) && psel && !penable;
    assign pready   = (state_q == ACCESS) && penable && (cnt_q == 4'd0);
    assign complete = pready && psel;
    assign pslverr  = pready && err_q;
    assign prdata   = (pready && !wr_q && !err_q) ? mem[idx_q] : '0;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= '0;
            cnt_q      <= 4'd0;
            lfsr_q     <= LFSR_SEED;
            xfer_count <= 16'd0;
            err_count  <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    // penable without a preceding setup is not a setup and is ignored here.
                    if (setup) begin
                        state_q <= ACCESS;
                        idx_q   <= word_idx[IDX_W-1:0];
                        wr_q    <= pwrite;
                        err_q   <= addr_err;
                        wdata_q <= pwdata;
                        cnt_q   <= wait_load;
                        if (WAIT_MODE == 2) begin
                            lfsr_q <= lfsr_next;
                        end
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        // Master abandoned the transfer: drop it without side effects.
                        state_q <= IDLE;
                    end else if (complete) begin
                        state_q <= IDLE;
                        if (err_q) begin
                            err_count <= err_count + 16'd1;
                        end else begin
                            xfer_count <= xfer_count + 16'd1;
                        end
                    end else if (penable && (cnt_q != 4'd0)) begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage is not reset; a reset on the completion edge suppresses the commit.
    always_ff @(posedge pclk) begin
        if (!preset && complete && wr_q && !err_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_amba3_apb_mem_slave.sv
module tb_amba3_apb_mem_slave;

    logic        clk = 1'b0;
    logic        preset;
    logic        psel       [3];
    logic        penable    [3];
    logic        pwrite     [3];
    logic [31:0] paddr      [3];
    logic [31:0] pwdata     [3];
    logic [31:0] prdata     [3];
    logic        pready     [3];
    logic        pslverr    [3];
    logic [15:0] xfer_count [3];
    logic [15:0] err_count  [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Unit 0: zero wait. Unit 1: fixed 3 waits. Unit 2: random 0..10 waits.
    amba3_apb_mem_slave #(.WAIT_MODE(0), .WAIT_CYCLES(0)) u_zero (
        .pclk(clk), .preset(preset), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]),
        .pready(pready[0]), .pslverr(pslverr[0]), .xfer_count(xfer_count[0]),
        .err_count(err_count[0])
    );

    amba3_apb_mem_slave #(.WAIT_MODE(1), .WAIT_CYCLES(3)) u_fixed (
        .pclk(clk), .preset(preset), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]),
        .pready(pready[1]), .pslverr(pslverr[1]), .xfer_count(xfer_count[1]),
        .err_count(err_count[1])
    );

    amba3_apb_mem_slave #(.WAIT_MODE(2), .WAIT_CYCLES(10)) u_rand (
        .pclk(clk), .preset(preset), .psel(psel[2]), .penable(penable[2]),
        .pwrite(pwrite[2]), .paddr(paddr[2]), .pwdata(pwdata[2]), .prdata(prdata[2]),
        .pready(pready[2]), .pslverr(pslverr[2]), .xfer_count(xfer_count[2]),
        .err_count(err_count[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller is just after a rising edge. Returns just after the completion edge with
    // psel dropped, so an immediately following call is a back-to-back setup.
    task automatic apb_xfer(input int u, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, output logic [31:0] rd,
                            output logic err, output int waits, output logic ok);
        rd    = '0;
        err   = 1'b0;
        waits = 0;
        ok    = 1'b0;
        psel[u]    = 1'b1;
        penable[u] = 1'b0;
        pwrite[u]  = wr;
        paddr[u]   = addr;
        pwdata[u]  = wd;
        @(posedge clk); #1;
        penable[u] = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (pready[u]) begin
                rd  = prdata[u];
                err = pslverr[u];
                ok  = 1'b1;
                break;
            end
            waits++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        psel[u]    = 1'b0;
        penable[u] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] rd;
    logic        er;
    int          w;
    logic        ok;
    logic [31:0] sb    [1024];
    logic [31:0] wlist [200];
    int          order [200];
    int          j;
    int          t;
    int          wmin;
    int          wmax;
    logic [31:0] a;
    logic [31:0] d;

    initial begin
        for (int u = 0; u < 3; u++) begin
            psel[u] = 1'b0; penable[u] = 1'b0; pwrite[u] = 1'b0;
            paddr[u] = '0;  pwdata[u] = '0;
        end
        preset = 1'b1;
        repeat (3) @(posedge clk);
        #1 preset = 1'b0;

        // Reset state.
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            chk("rst_pready",  32'(pready[u]),     32'd0);
            chk("rst_pslverr", 32'(pslverr[u]),    32'd0);
            chk("rst_prdata",  prdata[u],          32'd0);
            chk("rst_xfer",    32'(xfer_count[u]), 32'd0);
            chk("rst_err",     32'(err_count[u]),  32'd0);
        end
        @(posedge clk); #1;

        // penable with no setup phase is ignored.
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 32'h40;
        @(negedge clk);
        chk("nosetup_rdy0", 32'(pready[0]), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("nosetup_rdy1", 32'(pready[0]), 32'd0);
        @(posedge clk); #1;
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(posedge clk); #1;
        chk("nosetup_xfer", 32'(xfer_count[0]), 32'd0);

        // Zero wait write/read, issued back to back.
        apb_xfer(0, 1'b1, 32'h40, 32'h80003333, rd, er, w, ok);
        chk("zw_wr_ok", 32'(ok), 32'd1);
        chk("zw_wr_wait", 32'(w), 32'd0);
        chk("zw_wr_err", 32'(er), 32'd0);
        apb_xfer(0, 1'b0, 32'h40, 32'h0, rd, er, w, ok);
        chk("zw_rd_wait", 32'(w), 32'd0);
        chk("zw_rd_data", rd, 32'h80003333);
        chk("zw_xfer", 32'(xfer_count[0]), 32'd2);

        // Error responses.
        apb_xfer(0, 1'b1, 32'h1000, 32'hDEADBEEF, rd, er, w, ok);
        chk("err_oow_slverr", 32'(er), 32'd1);
        chk("err_oow_prdata", rd, 32'd0);
        apb_xfer(0, 1'b1, 32'h42, 32'hDEADBEEF, rd, er, w, ok);
        chk("err_mis_slverr", 32'(er), 32'd1);
        chk("err_cnt2", 32'(err_count[0]), 32'd2);
        apb_xfer(0, 1'b0, 32'h40, 32'h0, rd, er, w, ok);
        chk("err_keep_data", rd, 32'h80003333);
        chk("err_keep_slverr", 32'(er), 32'd0);
        apb_xfer(0, 1'b0, 32'h1000, 32'h0, rd, er, w, ok);
        chk("err_rd_slverr", 32'(er), 32'd1);
        chk("err_rd_prdata", rd, 32'd0);
        chk("err_cnt3", 32'(err_count[0]), 32'd3);
        chk("err_xfer3", 32'(xfer_count[0]), 32'd3);

        // Last word of the window is valid.
        apb_xfer(0, 1'b1, 32'hFFC, 32'h5A5AA5A5, rd, er, w, ok);
        chk("top_wr_slverr", 32'(er), 32'd0);
        apb_xfer(0, 1'b0, 32'hFFC, 32'h0, rd, er, w, ok);
        chk("top_rd_data", rd, 32'h5A5AA5A5);
        chk("top_xfer", 32'(xfer_count[0]), 32'd5);

        // Fixed three wait states.
        apb_xfer(1, 1'b1, 32'h84, 32'h04400011, rd, er, w, ok);
        chk("fix_wr_ok", 32'(ok), 32'd1);
        chk("fix_wr_wait", 32'(w), 32'd3);
        apb_xfer(1, 1'b0, 32'h84, 32'h0, rd, er, w, ok);
        chk("fix_rd_wait", 32'(w), 32'd3);
        chk("fix_rd_data", rd, 32'h04400011);
        chk("fix_xfer", 32'(xfer_count[1]), 32'd2);

        // Abort during a wait state; bus values changed mid-access are ignored too.
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 32'h84; pwdata[1] = 32'hDEADBEEF;
        @(posedge clk); #1;
        penable[1] = 1'b1; paddr[1] = 32'h88; pwdata[1] = 32'h0;
        @(negedge clk);
        chk("abort_wait_rdy", 32'(pready[1]), 32'd0);
        @(posedge clk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(posedge clk); #1;
        chk("abort_xfer", 32'(xfer_count[1]), 32'd2);
        chk("abort_err", 32'(err_count[1]), 32'd0);
        apb_xfer(1, 1'b0, 32'h84, 32'h0, rd, er, w, ok);
        chk("abort_mem", rd, 32'h04400011);

        // Random waits against a scoreboard. First waits follow from the seed ACE1.
        wmin = 99; wmax = -1;
        for (int i = 0; i < 200; i++) begin
            a = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
            d = $urandom;
            wlist[i] = a;
            order[i] = i;
            sb[a[11:2]] = d;
            apb_xfer(2, 1'b1, a, d, rd, er, w, ok);
            chk("rnd_wr_ok", 32'(ok), 32'd1);
            if (i == 0) chk("rnd_wait0", 32'(w), 32'd1);
            if (i == 1) chk("rnd_wait1", 32'(w), 32'd0);
            if (i == 2) chk("rnd_wait2", 32'(w), 32'd8);
            if (w < wmin) wmin = w;
            if (w > wmax) wmax = w;
        end
        for (int i = 199; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 200; i++) begin
            a = wlist[order[i]];
            apb_xfer(2, 1'b0, a, 32'h0, rd, er, w, ok);
            chk("rnd_rd_ok", 32'(ok), 32'd1);
            chk("rnd_rd_data", rd, sb[a[11:2]]);
            if (w < wmin) wmin = w;
            if (w > wmax) wmax = w;
        end
        chk("rnd_wait_max_le10", 32'(wmax <= 10), 32'd1);
        chk("rnd_wait_min_ge0", 32'(wmin >= 0), 32'd1);
        chk("rnd_wait_varied", 32'(wmin != wmax), 32'd1);
        chk("rnd_xfer", 32'(xfer_count[2]), 32'd400);

        // Reset in the middle of a waited write.
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 32'h84; pwdata[1] = 32'h12345678;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(posedge clk); #1;
        preset = 1'b1;
        @(posedge clk); #1;
        preset = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
        @(negedge clk);
        chk("rstmid_pready", 32'(pready[1]), 32'd0);
        chk("rstmid_xfer1", 32'(xfer_count[1]), 32'd0);
        chk("rstmid_err1", 32'(err_count[1]), 32'd0);
        chk("rstmid_xfer0", 32'(xfer_count[0]), 32'd0);
        chk("rstmid_err0", 32'(err_count[0]), 32'd0);
        @(posedge clk); #1;
        apb_xfer(1, 1'b0, 32'h84, 32'h0, rd, er, w, ok);
        chk("rstmid_mem1", rd, 32'h04400011);
        chk("rstmid_xfer_after", 32'(xfer_count[1]), 32'd1);
        apb_xfer(0, 1'b0, 32'h40, 32'h0, rd, er, w, ok);
        chk("rstmid_mem0", rd, 32'h80003333);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/amba3_apb_mem_slave.md
# amba3_apb_mem_slave

Synthesizable AMBA 3 APB slave: a parametrised word-addressed memory with configurable wait-state insertion (none, fixed or pseudo-random) and PSLVERR signalling for out-of-window and misaligned accesses. It sits behind the APB interconnect as the RTL counterpart of the behavioural slave model. Benches drive it with the existing APB master VIP, and designs use it as scratch RAM or as a register-file stub.

## Interface
- ADDR_SIZE, 32, paddr width
- DATA_SIZE, 32, pwdata/prdata width; power of two, ≥ 8
- MEM_DEPTH, 1024, number of DATA_SIZE-bit words
- BASE_ADDR, 0, byte address of word 0; aligned to DATA_SIZE/8
- WAIT_MODE, 0, 0 = zero wait, 1 = fixed WAIT_CYCLES, 2 = pseudo-random 0..WAIT_CYCLES
- WAIT_CYCLES, 2, fixed or maximum wait states, 0..15
- LFSR_SEED, 16'hACE1, non-zero reset value of the wait LFSR
- pclk  in  1  clock; all logic on rising edge
- preset  in  1  synchronous, active-high reset
- psel  in  1  slave select
- penable  in  1  access phase
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDR_SIZE  byte address
- pwdata  in  DATA_SIZE  write data
- prdata  out  DATA_SIZE  read data
- pready  out  1  transfer completes this cycle
- pslverr  out  1  error response, valid only with pready
- xfer_count  out  16  completed non-error transfers, wraps
- err_count  out  16  completed error transfers, wraps

## Operation
- Word index = (paddr − BASE_ADDR) >> log2(DATA_SIZE/8).
- Error when paddr < BASE_ADDR, index ≥ MEM_DEPTH, or paddr[log2(DATA_SIZE/8)−1:0] ≠ 0.
- FSM states: IDLE, ACCESS.
  - IDLE → ACCESS on psel & !penable (setup cycle). On that edge: latch paddr, pwrite, error flag and pwdata; load wait counter; advance LFSR when WAIT_MODE = 2.
  - ACCESS → IDLE on psel & penable & pready (completion).
  - ACCESS → IDLE on !psel (aborted transfer): no write, no counter update.
- Wait counter load value by mode:
  - WAIT_MODE 0: 0.
  - WAIT_MODE 1: WAIT_CYCLES.
  - WAIT_MODE 2: lfsr[3:0] mod (WAIT_CYCLES+1).
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11.
- In ACCESS with psel & penable, the counter decrements each cycle while non-zero.
- pready = (state == ACCESS) & penable & (cnt == 0); combinational from registered state.
- Write completion: mem[index] ← latched pwdata at the completion edge, unless error.
- Read completion: prdata = mem[index] during the completion cycle. prdata is 0 at all other times and on error.
- pslverr = pready & error flag. An error write leaves memory untouched.
- xfer_count increments on each non-error completion; err_count on each error completion.
- Memory contents are not reset. Reads of never-written words are undefined; benches must not check them.

## Timing
- Reset values:
  - FSM: IDLE; pready 0, pslverr 0, prdata 0.
  - xfer_count 0, err_count 0.
  - Wait counter 0, LFSR = LFSR_SEED.
- Zero-wait transfer: setup cycle N, access cycle N+1 with pready = 1; the write is visible to a read whose setup is at N+2.
- Fixed wait W: pready rises in access cycle W+1, giving W low cycles first.
- Back-to-back: the cycle after completion may be a new setup. The FSM is in IDLE then and accepts it. No dead cycle.
- penable high without a preceding setup in IDLE is ignored; pready stays 0.
- preset asserted mid-transfer: next cycle is IDLE with pready 0 and counters 0. An uncompleted write does not commit. Memory contents are retained.
- paddr/pwrite/pwdata changing during ACCESS has no effect; latched values are used.

## Test plan
- Zero wait, DATA_SIZE 32: write 0x0040 ← 0x80003333, then read 0x0040 → prdata 0x80003333. pready high on the first access cycle of each; xfer_count = 2.
- WAIT_MODE 1, WAIT_CYCLES 3: write 0x0084 ← 0x04400011 → pready low for exactly 3 access cycles, high on the 4th. Read back matches.
- Errors with MEM_DEPTH 1024: write to 0x1000 (out of window) and to 0x0042 (misaligned) → pready with pslverr 1, prdata 0, err_count = 2. A read of 0x0040 returns its prior value.
- WAIT_MODE 2, WAIT_CYCLES 10, 200 random aligned writes then shuffled reads → every read matches a scoreboard. Wait counts stay within 0..10 and are not all equal; xfer_count = 400.
- Abort and reset: drop psel during a wait state of a write → memory unchanged, counters unchanged. Assert preset mid-write → pready 0, counters 0, and earlier written data still reads back.
